sub_serial: RTL and testbench
=============================

SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled high in IDLE or DONE to begin an operation.
REQ-006 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-007 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results are valid.
REQ-010 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 carry  output  1  borrow out of the MSB: 1 iff a < b unsigned.
REQ-012 overflow  output  1  two's-complement overflow of a - b.
REQ-013 zero  output  1  1 iff diff == 0.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL capture a, b, clear the internal borrow, clear the chunk counter and go to RUN; with start=0 it SHALL stay in IDLE.
REQ-016 RUN SHALL process one CHUNK per cycle, LSB chunk first, propagating the borrow between chunks through a register.
REQ-017 RUN SHALL last exactly WIDTH/CHUNK cycles (4 at defaults), then go to DONE.
REQ-018 Latency: with start sampled at edge k, done SHALL be high for the cycle following edge k+WIDTH/CHUNK.
REQ-019 busy SHALL be high exactly while state == RUN.
REQ-020 diff, carry, overflow and zero SHALL be registered on entry to DONE and held until the next accepted start.
REQ-021 overflow SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-022 DONE SHALL last one cycle; with start=1 it SHALL accept the new operands and go directly to RUN, otherwise it SHALL go to IDLE.
REQ-023 start while in RUN SHALL be ignored; operands captured earlier SHALL NOT change.
REQ-024 a and b changing after the accepting edge SHALL NOT affect the result.
REQ-025 The chunk counter SHALL wrap to 0 when leaving RUN; no state other than the three defined states SHALL be reachable.

Reset
REQ-026 reset SHALL force state IDLE, busy=0, done=0, diff=0, carry=0, overflow=0, zero=0, and clear the captured operands, borrow and counter, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-028 After reset deasserts, the first start sampled high SHALL begin a fresh operation.

Structure
REQ-029 The FSM state encoding and the default WIDTH/CHUNK values SHALL reside in a shared processor package/include used by the ALU blocks.
REQ-030 A combinational sub-module sub_chunk (CHUNK-bit a, b, borrow_in -> diff, borrow_out) SHALL be instantiated once; the top SHALL hold only the FSM, counter and registers.
REQ-031 The block SHALL contain no latches and no combinational path from start, a or b to any output.

Verification
REQ-032 a=0006, b=0004, start pulse -> 4 cycles later done=1, diff=0002, carry=0, overflow=0, zero=0.
REQ-033 a=0000, b=0001 -> diff=FFFF, carry=1, overflow=0; a=8000, b=0001 -> diff=7FFF, carry=0, overflow=1.
REQ-034 a=7FFF, b=FFFF -> diff=8000, carry=1, overflow=1; a=1234, b=1234 -> diff=0000, zero=1, carry=0.
REQ-035 start re-pulsed with a=FFFF, b=FFFF during RUN of 0006-0004 -> result still 0002; exactly one done pulse.
REQ-036 Back-to-back: start held high through DONE with a new operand pair -> busy deasserts for only the DONE cycle; the second done follows 4 cycles later with the correct second result.
REQ-037 reset asserted in the 2nd RUN cycle -> all outputs 0 immediately, busy=0, no done within 10 following cycles.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared definitions for the chunk-serial subtractor: default geometry,
// FSM state encoding and a counter-width helper.
package sub_serial_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0 .. n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_serial_chunk.sv
// Combinational CHUNK-bit subtract slice: diff = a - b - borrow_in,
// borrow_out is the borrow leaving the slice MSB.
module sub_chunk
    import sub_serial_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             borrow_i,
    output logic [CHUNK-1:0] diff_o,
    output logic             borrow_o
);

    // One extra bit on the left catches the borrow as the sign of the result.
    assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, borrow_i};

endmodule

// File: rtl/sub_serial.sv
// Chunk-serial subtractor: captures a and b on start, subtracts CHUNK bits
// per cycle LSB first with a registered borrow, then presents diff and the
// flags for one done cycle and holds them until the next accepted start.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int             NCHUNK   = WIDTH / CHUNK;
    localparam int             CW       = cnt_width(NCHUNK);
    localparam logic [CW-1:0]  LAST_CNT = CW'(NCHUNK - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             borrow_q;
    logic [WIDTH-1:0] acc_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] diff_q;
    logic             carry_q, overflow_q, zero_q;

    logic [CHUNK-1:0] a_chunk, b_chunk, chunk_diff;
    logic             chunk_borrow;
    logic [WIDTH-1:0] acc_d;
    logic             overflow_d, zero_d;

    // Select the operand slices addressed by the chunk counter and form the
    // next partial result plus the flags it would produce on the last chunk.
    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        a_chunk    = CHUNK'(a_q >> (int'(cnt_q) * CHUNK));
        b_chunk    = CHUNK'(b_q >> (int'(cnt_q) * CHUNK));
        acc_d      = (acc_q >> CHUNK) | (WIDTH'(chunk_diff) << (WIDTH - CHUNK));
        overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
        zero_d     = (acc_d == '0);
    end

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i      (a_chunk),
        .b_i      (b_chunk),
        .borrow_i (borrow_q),
        .diff_o   (chunk_diff),
        .borrow_o (chunk_borrow)
    );

    // Control FSM, chunk counter, operand capture and registered outputs.
    // NOTE: all state here is assigned with <= so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            borrow_q   <= 1'b0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    borrow_q <= chunk_borrow;
                    acc_q    <= acc_d;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        diff_q     <= acc_d;
                        carry_q    <= chunk_borrow;
                        overflow_q <= overflow_d;
                        zero_q     <= zero_d;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q      <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: a transaction-level model predicts the
// outputs each cycle, and directed vectors pin literal results and latency.
module tb_sub_serial;

    localparam int W   = 16;
    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b;
    logic         busy, done, carry, overflow, zero;
    logic [W-1:0] diff;

    int n_vec = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    sub_serial #(
        .WIDTH (W),
        .CHUNK (NCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signed-range test of the true difference.
    function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    // Transaction model: an accepted operation stays busy NCH cycles, then
    // publishes its arithmetic result with a one-cycle done.
    logic         m_busy, m_done, m_carry, m_ovf, m_zero;
    logic [W-1:0] m_diff, p_diff;
    logic         p_carry, p_ovf;
    int           m_rem;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_diff <= '0;
            m_carry <= 1'b0; m_ovf <= 1'b0; m_zero <= 1'b0;
            p_diff <= '0; p_carry <= 1'b0; p_ovf <= 1'b0; m_rem <= 0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_diff  <= p_diff;
                m_carry <= p_carry;
                m_ovf   <= p_ovf;
                m_zero  <= (p_diff == '0);
            end
        end else if (start) begin
            p_diff  <= a - b;
            p_carry <= (a < b);
            p_ovf   <= ovf_of(a, b);
            m_busy  <= 1'b1;
            m_rem   <= NCH;
            m_done  <= 1'b0;
        end else begin
            m_done  <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy", busy, m_busy);
            check("cmp_done", done, m_done);
            check("cmp_diff", diff, m_diff);
            check("cmp_carry", carry, m_carry);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_zero", zero, m_zero);
        end
    end

    // One operation with a start pulse, scrambled operands afterwards, and
    // literal checks of latency and results.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic ec, input logic eo,
                          input logic ez);
        int lat;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = 16'h5A5A;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency %h-%h", ta, tb_v), lat, NCH + 1);
        check($sformatf("diff %h-%h", ta, tb_v), diff, ed);
        check($sformatf("carry %h-%h", ta, tb_v), carry, ec);
        check($sformatf("overflow %h-%h", ta, tb_v), overflow, eo);
        check($sformatf("zero %h-%h", ta, tb_v), zero, ez);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, dones;
        logic [W-1:0] got;
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        reset = 1'b0;

        // Basic and boundary vectors.
        run_op(16'h0006, 16'h0004, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Start re-pulsed during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; a = 16'h0006; b = 16'h0004;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        dones = 0; got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                got = diff;
            end
        end
        check("ignore_done_count", dones, 1);
        check("ignore_diff", got, 16'h0002);

        // Back-to-back: start held through DONE with a new operand pair.
        @(negedge clk);
        start = 1'b1; a = 16'h0100; b = 16'h0001;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_latency", lat, NCH + 1);
        check("b2b_first_diff", diff, 16'h00FF);
        check("b2b_done_busy", busy, 0);
        a = 16'h0003; b = 16'h0005;
        @(negedge clk);
        check("b2b_rerun_busy", busy, 1);
        check("b2b_rerun_done", done, 0);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, NCH + 1);
        check("b2b_second_diff", diff, 16'hFFFE);
        check("b2b_second_carry", carry, 1);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; a = 16'h0F00; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_carry", carry, 0);
        check("abort_overflow", overflow, 0);
        check("abort_zero", zero, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // First start after reset begins a fresh operation.
        run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
